// File: rtl/sram_req_arbiter_if.sv
// Bus bundle between the CPU masters, the arbiter and the SRAM-like slave.
// slave: arbiter view (m_* in, s_* out); master: the surrounding pipeline/bridge.
interface sram_req_arbiter_if;
   logic [1:0]  m_req;
   logic [1:0]  m_wr;
   logic [3:0]  m_size;
   logic [7:0]  m_wstrb;
   logic [63:0] m_addr;
   logic [63:0] m_wdata;
   logic [1:0]  m_addr_ok;
   logic [1:0]  m_data_ok;
   logic [31:0] m_rdata;
   logic        s_req;
   logic        s_wr;
   logic [1:0]  s_size;
   logic [3:0]  s_wstrb;
   logic [31:0] s_addr;
   logic [31:0] s_wdata;
   logic        s_addr_ok;
   logic        s_data_ok;
   logic [31:0] s_rdata;

   modport slave (
      input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
      input  s_addr_ok, s_data_ok, s_rdata,
      output m_addr_ok, m_data_ok, m_rdata,
      output s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata
   );

   modport master (
      output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
      output s_addr_ok, s_data_ok, s_rdata,
      input  m_addr_ok, m_data_ok, m_rdata,
      input  s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata
   );
endinterface

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like bus between inst (master 0) and data (master 1).
// Ports: clk, rst (async active-low), bus (slave modport).
// Optional SRAM_ARB_RR_EN: round-robin when both masters request.
module sram_req_arbiter #(
   parameter int DEPTH = 4
) (
   input logic clk,
   input logic rst,
   sram_req_arbiter_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t           state_q, state_d;
   logic             lock_id_q, lock_id_d;
   logic [DEPTH-1:0] owner_q;
   logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             gnt_vld, gnt, sel;
   logic             accept, ret, head;
`ifdef SRAM_ARB_RR_EN
   logic             last_id_q;
`endif

   // A stalled address phase keeps its grant until the slave takes it.
   always_comb begin
      gnt_vld = 1'b0;
      gnt     = 1'b0;
      if (state_q == LOCKED) begin
         gnt_vld = 1'b1;
         gnt     = lock_id_q;
      end else if (cnt_q != FULL) begin
         gnt_vld = |bus.m_req;
         gnt     = bus.m_req[1];
`ifdef SRAM_ARB_RR_EN
         if (&bus.m_req)
            gnt = ~last_id_q;
`endif
      end
   end

   assign sel    = rst & gnt_vld;
   assign head   = owner_q[rd_ptr_q];
   assign accept = bus.s_req & bus.s_addr_ok;
   assign ret    = rst & bus.s_data_ok & (cnt_q != '0);

   always_comb begin
      bus.s_req   = sel & bus.m_req[gnt];
      bus.s_wr    = 1'b0;
      bus.s_size  = '0;
      bus.s_wstrb = '0;
      bus.s_addr  = '0;
      bus.s_wdata = '0;
      if (sel) begin
         bus.s_wr    = bus.m_wr[gnt];
         bus.s_size  = gnt ? bus.m_size[3:2]    : bus.m_size[1:0];
         bus.s_wstrb = gnt ? bus.m_wstrb[7:4]   : bus.m_wstrb[3:0];
         bus.s_addr  = gnt ? bus.m_addr[63:32]  : bus.m_addr[31:0];
         bus.s_wdata = gnt ? bus.m_wdata[63:32] : bus.m_wdata[31:0];
      end
   end

   assign bus.m_addr_ok = {accept & gnt, accept & ~gnt};
   assign bus.m_data_ok = {ret & head, ret & ~head};
   assign bus.m_rdata   = rst ? bus.s_rdata : '0;

   always_comb begin
      state_d   = state_q;
      lock_id_d = lock_id_q;
      unique case (state_q)
         IDLE: begin
            if (bus.s_req & ~bus.s_addr_ok) begin
               state_d   = LOCKED;
               lock_id_d = gnt;
            end
         end
         LOCKED: begin
            if (bus.s_addr_ok)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      cnt_d = cnt_q;
      unique case ({accept, ret})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         lock_id_q <= 1'b0;
         owner_q   <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         cnt_q     <= '0;
`ifdef SRAM_ARB_RR_EN
         last_id_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
         cnt_q     <= cnt_d;
         if (accept) begin
            owner_q[wr_ptr_q] <= gnt;
            wr_ptr_q          <= wr_ptr_q + AW'(1);
`ifdef SRAM_ARB_RR_EN
            last_id_q         <= gnt;
`endif
         end
         if (ret)
            rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter: queue-based reference model
// checked every cycle, plus directed literal expectations.
module tb_sram_req_arbiter;
   localparam int DEPTH = 4;
`ifdef SRAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sram_req_arbiter_if bus();
   sram_req_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: outstanding owners in issue order, plus the
   // master whose address phase is stalled (if any).
   bit q[$];
   bit lk_v, lk_id, last;

   always @(negedge clk) begin
      bit gv, g, sreq, acc, rt;
      int gi;
      logic [11:0] e_ctl;
      logic [31:0] e_addr, e_wdata, e_rdata;
      gv = 1'b0;
      g  = 1'b0;
      if (!rst) begin
         e_ctl   = '0;
         e_addr  = '0;
         e_wdata = '0;
         e_rdata = '0;
         q.delete();
         lk_v = 1'b0;
         lk_id = 1'b0;
         last = 1'b0;
      end else begin
         if (lk_v) begin
            gv = 1'b1;
            g  = lk_id;
         end else if (q.size() < DEPTH && bus.m_req != 2'b00) begin
            gv = 1'b1;
            if (bus.m_req == 2'b11) g = RR ? ~last : 1'b1;
            else g = bus.m_req[1];
         end
         gi   = int'(g);
         sreq = gv && bus.m_req[gi];
         acc  = sreq && bus.s_addr_ok;
         rt   = bus.s_data_ok && q.size() > 0;
         e_ctl[11]   = sreq;
         e_ctl[10]   = gv ? bus.m_wr[gi] : 1'b0;
         e_ctl[9:8]  = gv ? bus.m_size[gi*2 +: 2] : 2'b00;
         e_ctl[7:4]  = gv ? bus.m_wstrb[gi*4 +: 4] : 4'h0;
         e_ctl[3:2]  = acc ? (g ? 2'b10 : 2'b01) : 2'b00;
         e_ctl[1:0]  = rt ? (q[0] ? 2'b10 : 2'b01) : 2'b00;
         e_addr  = gv ? bus.m_addr[gi*32 +: 32] : 32'h0;
         e_wdata = gv ? bus.m_wdata[gi*32 +: 32] : 32'h0;
         e_rdata = bus.s_rdata;
         if (rt) void'(q.pop_front());
         if (acc) begin
            q.push_back(g);
            last = g;
         end
         if (bus.s_addr_ok) lk_v = 1'b0;
         else if (sreq) begin
            lk_v  = 1'b1;
            lk_id = g;
         end
      end
      chk("m_ctl", {bus.s_req, bus.s_wr, bus.s_size, bus.s_wstrb,
                    bus.m_addr_ok, bus.m_data_ok}, e_ctl);
      chk("m_saddr", bus.s_addr, e_addr);
      chk("m_swdata", bus.s_wdata, e_wdata);
      chk("m_rdata", bus.m_rdata, e_rdata);
   end

   task automatic drive(input logic [1:0] req, input logic aok,
                        input logic dok, input logic [31:0] rd);
      @(posedge clk);
      #1;
      bus.m_req     = req;
      bus.s_addr_ok = aok;
      bus.s_data_ok = dok;
      bus.s_rdata   = rd;
      @(negedge clk);
   endtask

   task automatic drain();
      repeat (DEPTH + 1) drive(2'b00, 1'b0, 1'b1, 32'hee);
      drive(2'b00, 1'b0, 1'b0, 32'h0);
   endtask

   localparam logic [1:0] T3_DOK [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
   localparam logic [1:0] T1_RR  [3] = '{2'b10, 2'b01, 2'b10};
   localparam logic [1:0] T6_RR  [3] = '{2'b01, 2'b10, 2'b01};

   initial begin
      bus.m_req     = 2'b00;
      bus.m_wr      = 2'b00;
      bus.m_size    = {2'd2, 2'd1};
      bus.m_wstrb   = {4'hf, 4'h3};
      bus.m_addr    = {32'h80001000, 32'h1c000000};
      bus.m_wdata   = {32'hdddd0001, 32'h11110002};
      bus.s_addr_ok = 1'b0;
      bus.s_data_ok = 1'b0;
      bus.s_rdata   = 32'h0;
      @(negedge clk);
      chk("reset_aok", bus.m_addr_ok, 2'b00);
      @(posedge clk);
      #1 rst = 1'b1;

      // both masters request, slave accepts every cycle
      bus.m_wr = 2'b10;
      for (int i = 0; i < 3; i++) begin
         drive(2'b11, 1'b1, i > 0, 32'h100 + i);
         chk("t1_aok", bus.m_addr_ok, RR ? T1_RR[i] : 2'b10);
      end
      drain();
      bus.m_wr = 2'b00;

      // stalled inst request holds the bus
      drive(2'b01, 1'b0, 1'b0, 32'h0);
      chk("t2_addr0", bus.s_addr, 32'h1c000000);
      for (int i = 0; i < 2; i++) begin
         drive(2'b11, 1'b0, 1'b0, 32'h0);
         chk("t2_hold", bus.s_addr, 32'h1c000000);
         chk("t2_noaok", bus.m_addr_ok, 2'b00);
      end
      drive(2'b11, 1'b1, 1'b0, 32'h0);
      chk("t2_aok", bus.m_addr_ok, 2'b01);
      chk("t2_addr1", bus.s_addr, 32'h1c000000);
      drive(2'b10, 1'b1, 1'b0, 32'h0);
      chk("t2_data", bus.m_addr_ok, 2'b10);
      chk("t2_daddr", bus.s_addr, 32'h80001000);
      drain();

      // in-order return routing
      drive(2'b01, 1'b1, 1'b0, 32'h0);
      drive(2'b10, 1'b1, 1'b0, 32'h0);
      drive(2'b01, 1'b1, 1'b0, 32'h0);
      drive(2'b10, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         drive(2'b00, 1'b0, 1'b1, 32'ha + i);
         chk("t3_dok", bus.m_data_ok, T3_DOK[i]);
         chk("t3_rdata", bus.m_rdata, 32'ha + i);
      end
      drive(2'b00, 1'b0, 1'b1, 32'h77);
      chk("t3_empty", bus.m_data_ok, 2'b00);

      // full: no grant until the cycle after a return
      repeat (4) drive(2'b11, 1'b1, 1'b0, 32'h0);
      drive(2'b11, 1'b1, 1'b0, 32'h0);
      chk("t4_full_req", bus.s_req, 1'b0);
      drive(2'b11, 1'b1, 1'b1, 32'h55);
      chk("t4_ret_req", bus.s_req, 1'b0);
      chk("t4_ret_dok", bus.m_data_ok, RR ? 2'b01 : 2'b10);
      drive(2'b11, 1'b1, 1'b0, 32'h0);
      chk("t4_regrant", bus.s_req, 1'b1);
      chk("t4_aok", bus.m_addr_ok, RR ? 2'b01 : 2'b10);
      drain();

      // simultaneous accept and return at two outstanding
      drive(2'b01, 1'b1, 1'b0, 32'h0);
      drive(2'b01, 1'b1, 1'b0, 32'h0);
      drive(2'b10, 1'b1, 1'b1, 32'h21);
      chk("t5_aok", bus.m_addr_ok, 2'b10);
      chk("t5_dok", bus.m_data_ok, 2'b01);
      drive(2'b00, 1'b0, 1'b1, 32'h22);
      chk("t5_dok2", bus.m_data_ok, 2'b01);
      drive(2'b00, 1'b0, 1'b1, 32'h23);
      chk("t5_dok3", bus.m_data_ok, 2'b10);
      drive(2'b00, 1'b0, 1'b1, 32'h24);
      chk("t5_empty", bus.m_data_ok, 2'b00);

      // async reset while locked with three outstanding
      repeat (3) drive(2'b01, 1'b1, 1'b0, 32'h0);
      drive(2'b10, 1'b0, 1'b0, 32'h0);
      chk("t6_lockreq", bus.s_req, 1'b1);
      @(posedge clk);
      #3;
      rst = 1'b0;
      bus.s_data_ok = 1'b1;
      bus.m_req = 2'b11;
      #1;
      chk("t6_rst_req", bus.s_req, 1'b0);
      chk("t6_rst_ok", {bus.m_addr_ok, bus.m_data_ok}, 4'h0);
      chk("t6_rst_addr", bus.s_addr, 32'h0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.m_req = 2'b01;
      bus.s_addr_ok = 1'b1;
      bus.s_data_ok = 1'b0;
      @(negedge clk);
      chk("t6_inst", bus.m_addr_ok, 2'b01);
      drive(2'b10, 1'b1, 1'b0, 32'h0);
      chk("t6_data", bus.m_addr_ok, 2'b10);
      for (int i = 0; i < 3; i++) begin
         drive(2'b11, 1'b1, 1'b1, 32'h60 + i);
         chk("t6_alt", bus.m_addr_ok, RR ? T6_RR[i] : 2'b10);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one SRAM-like bus between the fetch stage (master 0, inst) and the MEM stage (master 1, data).
- Accepts address phases in order and records the owner of each accepted request in an in-order owner FIFO.
- Routes each returning data_ok and rdata back to the master that issued the request.
- Sits between the CPU pipeline and the SRAM/AXI bridge. The WB stage consumes the data returned to master 1.

Parameters:
DEPTH, 4, maximum number of accepted-but-unreturned requests (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
m_req  in  2  per-master request; bit0 inst, bit1 data
m_wr  in  2  per-master write flag
m_size  in  4  per-master size, {data[3:2], inst[1:0]}
m_wstrb  in  8  per-master byte strobes, {data[7:4], inst[3:0]}
m_addr  in  64  per-master address, {data[63:32], inst[31:0]}
m_wdata  in  64  per-master write data, same packing
m_addr_ok  out  2  per-master address-phase accept
m_data_ok  out  2  per-master data-phase return
m_rdata  out  32  read data, broadcast to both masters
s_req  out  1  slave request
s_wr  out  1  slave write flag
s_size  out  2  slave size
s_wstrb  out  4  slave strobes
s_addr  out  32  slave address
s_wdata  out  32  slave write data
s_addr_ok  in  1  slave address-phase accept
s_data_ok  in  1  slave data-phase return
s_rdata  in  32  slave read data

Behaviour:
- State registers:
  - owner FIFO (DEPTH x 1 bit) with rd_ptr and wr_ptr of log2(DEPTH) bits, wrapping;
  - cnt (log2(DEPTH)+1 bits);
  - lock (1 bit) and lock_id (1 bit);
  - last_id (1 bit, used only with the optional feature).
- Reset (rst=0, asynchronous):
  - cnt=0, pointers=0, lock=0, lock_id=0, last_id=0.
  - All outputs forced 0 while rst=0.
- Grant is combinational:
  - State IDLE (lock=0): if cnt==DEPTH, no grant. Otherwise grant the data master if m_req[1], else the inst master if m_req[0].
  - State LOCKED (lock=1): grant = lock_id, unconditionally.
- s_req = granted master's req. s_wr, s_size, s_wstrb, s_addr and s_wdata are muxed from the granted master; they are 0 when nothing is granted.
- IDLE -> LOCKED: when s_req=1 and s_addr_ok=0. lock_id captures the grant. A pending request is never pre-empted.
- LOCKED -> IDLE: on s_addr_ok=1.
- Masters hold req and payload stable until their addr_ok. The arbiter does not check this.
- Accept (s_req & s_addr_ok), same cycle:
  - m_addr_ok[grant]=1;
  - owner FIFO[wr_ptr] <= grant; wr_ptr+1; cnt+1.
  - Zero added latency on the address phase.
- Return (s_data_ok=1 and cnt!=0), same cycle:
  - m_data_ok[FIFO[rd_ptr]]=1; m_rdata=s_rdata; rd_ptr+1; cnt-1.
  - Write responses also pop.
- Simultaneous accept and return: cnt unchanged, both pointers advance.
- Full (cnt==DEPTH): no new grant, even if a return occurs in the same cycle, because cnt is registered. LOCKED state is never entered from full.
- Empty (cnt==0): s_data_ok is ignored. No pop, m_data_ok=0, no pointer change.
- The slave never returns data_ok in the same cycle as the addr_ok of that request. The arbiter relies on this.
- m_rdata follows s_rdata combinationally at all times. It is qualified only by m_data_ok.

Optional Feature:
SRAM_ARB_RR_EN
- Defined:
  - last_id <= grant on every accept.
  - In IDLE with both m_req set, grant = ~last_id.
  - With a single requester, that requester is granted.
- Undefined: fixed priority, data over inst. last_id is not implemented.

Test Plan:
- Both m_req=2'b11, s_addr_ok=1 every cycle, RR_EN undefined -> m_addr_ok=2'b10 each cycle; inst is never accepted while data requests.
- Inst request at 0x1c000000 alone; s_addr_ok held 0 for 3 cycles; data req rises in cycle 2 -> s_addr stays 0x1c000000 until accept; m_addr_ok=2'b01; data granted the next cycle.
- Issue inst, data, inst, data (all reads); s_data_ok returns 0xA,0xB,0xC,0xD -> m_data_ok = 01,10,01,10 with m_rdata 0xA..0xD in order.
- DEPTH=4: accept 4 requests with no return -> cnt=4 and s_req=0 with m_req=2'b11. One s_data_ok -> s_req=1 the following cycle, not in the same cycle.
- Accept and return in the same cycle at cnt=2 -> cnt stays 2; s_data_ok with cnt=0 -> m_data_ok=00 and pointers unchanged.
- Assert rst=0 mid-cycle with cnt=3 and lock=1 -> outputs 0 immediately. After release, cnt=0 and a new request is granted in IDLE. With SRAM_ARB_RR_EN defined and m_req=11 held, grants alternate 01,10,01.
